// File: rtl/etapa_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/halt defaults,
// FSM encoding, IF/ID record layout and the PC alignment helper.
package etapa_fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0]    PC_RESET_DEF  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] NOP_WORD      = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC_STEP       = 32'd4;
    localparam logic [PC_W-1:0]    ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/etapa_fetch_sumador.sv
// Team 32-bit adder, wrap-around modulo 2^32 with no carry out.
module Sumador (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC register, IDLE/FETCH/HALT control and the
// IF/ID pipeline register feeding decode.
import etapa_fetch_pkg::*;

module etapa_fetch #(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_valid,
    output logic        o_halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pc_plus4;
    ifid_t        r_ifid;
    ifid_t        w_ifid_nxt;
    ifid_t        w_bubble;
    logic         w_fetch_done;
    logic         w_halt_hit;
    logic         w_load;

    Sumador u_pc_adder (
        .i_a   (r_pc),
        .i_b   (PC_STEP),
        .o_sum (w_pc_plus4)
    );

    assign w_fetch_done = (r_state == ST_FETCH) && i_imem_ready && !i_stall
                          && !i_redirect && !i_flush;
    assign w_halt_hit   = w_fetch_done && (i_imem_rdata == HALT_WORD);
    assign w_load       = w_fetch_done && !w_halt_hit;
    assign w_bubble     = '{pc_plus4: r_ifid.pc_plus4, instr: NOP_WORD, valid: 1'b0};

    // Next-state, next-PC and next-IF/ID selection.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ifid_nxt  = r_ifid;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_redirect) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_halt_hit) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (i_redirect) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A stalled or wait-state fetch keeps the PC so the word is re-requested.
        if (i_redirect) begin
            w_pc_nxt = align_word(i_redirect_target);
        end else if (i_stall) begin
            w_pc_nxt = r_pc;
        end else if (w_load) begin
            w_pc_nxt = w_pc_plus4;
        end else begin
            w_pc_nxt = r_pc;
        end

        if (i_flush || i_redirect) begin
            w_ifid_nxt = w_bubble;
        end else if (i_stall) begin
            w_ifid_nxt = r_ifid;
        end else if (w_load) begin
            w_ifid_nxt = '{pc_plus4: w_pc_plus4, instr: i_imem_rdata, valid: 1'b1};
        end else begin
            w_ifid_nxt = w_bubble;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= PC_RESET;
            r_ifid  <= '{pc_plus4: 32'h0000_0000, instr: NOP_WORD, valid: 1'b0};
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ifid  <= w_ifid_nxt;
        end
    end

    assign o_imem_req  = (r_state == ST_FETCH);
    assign o_imem_addr = r_pc;
    assign o_halted    = (r_state == ST_HALT);
    assign o_pc_plus4  = r_ifid.pc_plus4;
    assign o_instr     = r_ifid.instr;
    assign o_valid     = r_ifid.valid;

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed, table-driven bench for etapa_fetch; the memory model returns
// address + 0x100, except the halt word at address 0x10.
module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stall, i_flush, i_redirect, i_imem_ready;
    logic [31:0] i_redirect_target, i_imem_rdata;
    logic        o_imem_req, o_valid, o_halted;
    logic [31:0] o_imem_addr, o_pc_plus4, o_instr;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        v;
        logic [31:0] instr, pc4, addr;
        logic        req, halt;
    } vec_t;

    vec_t vecs[23];

    etapa_fetch dut (
        .clk               (clk),
        .reset             (rst_n),
        .i_stall           (i_stall),
        .i_flush           (i_flush),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_imem_req        (o_imem_req),
        .o_imem_addr       (o_imem_addr),
        .i_imem_rdata      (i_imem_rdata),
        .i_imem_ready      (i_imem_ready),
        .o_pc_plus4        (o_pc_plus4),
        .o_instr           (o_instr),
        .o_valid           (o_valid),
        .o_halted          (o_halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (o_imem_addr == 32'h0000_0010) i_imem_rdata = 32'hFFFF_FFFF;
        else                              i_imem_rdata = o_imem_addr + 32'h0000_0100;
    end

    function automatic vec_t mk(input logic st, fl, rd, input logic [31:0] tgt,
                                input logic rdy, v, input logic [31:0] instr, pc4, addr,
                                input logic req, halt);
        vec_t r;
        r.st = st; r.fl = fl; r.rd = rd; r.tgt = tgt; r.rdy = rdy;
        r.v = v; r.instr = instr; r.pc4 = pc4; r.addr = addr; r.req = req; r.halt = halt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input vec_t e);
        chk({tag, " valid"},  {31'd0, o_valid},    {31'd0, e.v});
        chk({tag, " instr"},  o_instr,             e.instr);
        chk({tag, " pc4"},    o_pc_plus4,          e.pc4);
        chk({tag, " addr"},   o_imem_addr,         e.addr);
        chk({tag, " req"},    {31'd0, o_imem_req}, {31'd0, e.req});
        chk({tag, " halted"}, {31'd0, o_halted},   {31'd0, e.halt});
    endtask

    initial begin
        int edges;
        vec_t zero_v;
        //              st    fl    rd    tgt           rdy   v     instr         pc4           addr          req   halt
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h4,        32'h4,        1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h8,        32'h8,        1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h8,        32'h8,        1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h8,        32'h8,        1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h8,        32'h8,        1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h108,      32'hC,        32'hC,        1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10C,      32'h10,       32'h10,       1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 32'h203,      1'b1, 1'b0, 32'h0,        32'h10,       32'h200,      1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      32'h204,      32'h204,      1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h204,      32'h204,      1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h304,      32'h208,      32'h208,      1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 32'h0,        32'h208,      32'h10,       1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h208,      32'h10,       1'b0, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h208,      32'h10,       1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h208,      32'h10,       1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 1'b0, 32'h0,        32'h208,      32'h40,       1'b1, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h140,      32'h44,       32'h44,       1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,       32'h44,       32'hFFFF_FFFC, 1'b1, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_00FC, 32'h0,       32'h0,        1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'h4,        32'h4,        1'b1, 1'b0);
        zero_v = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        rst_n = 1'b0;
        i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0;
        i_redirect_target = 32'h0; i_imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset", zero_v);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            i_stall = vecs[i].st;
            i_flush = vecs[i].fl;
            i_redirect = vecs[i].rd;
            i_redirect_target = vecs[i].tgt;
            i_imem_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in mid-cycle, checked before any further edge.
        i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0;
        i_redirect_target = 32'h0; i_imem_ready = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outputs("async_reset", zero_v);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            edges = n;
            if (o_valid) break;
        end
        chk("first_valid_edge", edges, 32'd2);
        chk("first_valid_instr", o_instr, 32'h100);
        chk("first_valid_pc4", o_pc_plus4, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
